// File: rtl/systemizer_seq_if.sv
// Host, systemizer and matrix-RAM signals of the systemizer sequencer.
// slave is the sequencer's view; master is the surrounding host/systemizer/RAM side.
interface systemizer_seq_if #(
    parameter int AW = 6,
    parameter int DW = 4
);
    logic          host_wr_en;
    logic [DW-1:0] host_wr_data;
    logic          host_rd_en;
    logic [DW-1:0] host_rd_data;
    logic          host_rd_valid;
    logic          cmd_run;
    logic          cmd_clear;
    logic [1:0]    op_left;
    logic [1:0]    op_right;
    logic          busy;
    logic          loaded;
    logic          status_success;
    logic          status_fail;
    logic          status_timeout;
    logic          err_access;
    logic          done_pulse;
    logic          sys_start;
    logic [1:0]    sys_gen_left_op;
    logic [1:0]    sys_gen_right_op;
    logic          sys_done;
    logic          sys_success;
    logic          sys_fail;
    logic          sys_rd_en;
    logic [AW-1:0] sys_rd_addr;
    logic [DW-1:0] sys_rd_data;
    logic          sys_wr_en;
    logic [AW-1:0] sys_wr_addr;
    logic [DW-1:0] sys_wr_data;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;

    modport slave (
        input  host_wr_en, host_wr_data, host_rd_en, cmd_run, cmd_clear, op_left, op_right,
        output host_rd_data, host_rd_valid, busy, loaded,
        output status_success, status_fail, status_timeout, err_access, done_pulse,
        output sys_start, sys_gen_left_op, sys_gen_right_op,
        input  sys_done, sys_success, sys_fail,
        input  sys_rd_en, sys_rd_addr, sys_wr_en, sys_wr_addr, sys_wr_data,
        output sys_rd_data,
        output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
        input  mem_rd_data
    );

    modport master (
        output host_wr_en, host_wr_data, host_rd_en, cmd_run, cmd_clear, op_left, op_right,
        input  host_rd_data, host_rd_valid, busy, loaded,
        input  status_success, status_fail, status_timeout, err_access, done_pulse,
        input  sys_start, sys_gen_left_op, sys_gen_right_op,
        output sys_done, sys_success, sys_fail,
        output sys_rd_en, sys_rd_addr, sys_wr_en, sys_wr_addr, sys_wr_data,
        input  sys_rd_data,
        input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
        output mem_rd_data
    );
endinterface

// File: rtl/systemizer_seq.sv
// Sequencer and matrix-RAM port arbiter for the systemizer core.
// Optional watchdog on the RUN phase is enabled with the SYS_WATCHDOG_EN macro.
module systemizer_seq #(
    parameter int DEPTH       = 40,
    parameter int AW          = 6,
    parameter int DW          = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input logic             clk,
    input logic             rst,
    systemizer_seq_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READY,
        S_RUN,
        S_READOUT,
        S_FAIL
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        state, state_n;
    logic [AW-1:0] ptr, ptr_n;
    logic [1:0]    left_q, right_q;
    logic          st_success, st_fail, err_q, done_q, start_q, valid_q;
    logic          host_wr_ok, host_rd_ok, launch, run_ok, run_fail, err_set, clear;
    logic          wd_expired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ptr        <= '0;
            left_q     <= '0;
            right_q    <= '0;
            st_success <= 1'b0;
            st_fail    <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            start_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            start_q <= launch;
            valid_q <= host_rd_ok;
            done_q  <= host_rd_ok && (ptr == LAST);
            if (launch) begin
                left_q     <= bus.op_left;
                right_q    <= bus.op_right;
                st_success <= 1'b0;
                st_fail    <= 1'b0;
            end
            if (run_ok)
                st_success <= 1'b1;
            if (run_fail)
                st_fail <= 1'b1;
            if (clear)
                err_q <= 1'b0;
            else if (err_set)
                err_q <= 1'b1;
        end
    end

    // cmd_clear outranks any host access in the same cycle outside RUN.
    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        host_wr_ok = 1'b0;
        host_rd_ok = 1'b0;
        launch     = 1'b0;
        run_ok     = 1'b0;
        run_fail   = 1'b0;
        err_set    = 1'b0;
        clear      = 1'b0;
        case (state)
            S_IDLE, S_LOAD: begin
                if (bus.cmd_clear) begin
                    clear   = 1'b1;
                    state_n = S_IDLE;
                    ptr_n   = '0;
                end else begin
                    if (bus.host_wr_en) begin
                        host_wr_ok = 1'b1;
                        if (ptr == LAST) begin
                            state_n = S_READY;
                            ptr_n   = '0;
                        end else begin
                            state_n = S_LOAD;
                            ptr_n   = ptr + AW'(1);
                        end
                    end
                    if (bus.host_rd_en || bus.cmd_run)
                        err_set = 1'b1;
                end
            end
            S_READY: begin
                if (bus.cmd_clear) begin
                    clear   = 1'b1;
                    state_n = S_IDLE;
                    ptr_n   = '0;
                end else begin
                    if (bus.cmd_run) begin
                        launch  = 1'b1;
                        state_n = S_RUN;
                    end
                    if (bus.host_wr_en || bus.host_rd_en)
                        err_set = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.host_wr_en || bus.host_rd_en)
                    err_set = 1'b1;
                if (bus.sys_done) begin
                    if (bus.sys_success && !bus.sys_fail) begin
                        run_ok  = 1'b1;
                        ptr_n   = '0;
                        state_n = S_READOUT;
                    end else begin
                        run_fail = 1'b1;
                        state_n  = S_FAIL;
                    end
                end else if (wd_expired) begin
                    run_fail = 1'b1;
                    state_n  = S_FAIL;
                end
            end
            S_READOUT: begin
                if (bus.cmd_clear) begin
                    clear   = 1'b1;
                    state_n = S_IDLE;
                    ptr_n   = '0;
                end else begin
                    if (bus.host_rd_en) begin
                        host_rd_ok = 1'b1;
                        if (ptr == LAST) begin
                            state_n = S_IDLE;
                            ptr_n   = '0;
                        end else begin
                            ptr_n = ptr + AW'(1);
                        end
                    end
                    if (bus.host_wr_en || bus.cmd_run)
                        err_set = 1'b1;
                end
            end
            S_FAIL: begin
                if (bus.cmd_clear) begin
                    clear   = 1'b1;
                    state_n = S_IDLE;
                    ptr_n   = '0;
                end else if (bus.host_wr_en || bus.host_rd_en || bus.cmd_run) begin
                    err_set = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                ptr_n   = '0;
            end
        endcase
    end

    // The systemizer owns both RAM ports for the whole run; otherwise only legal host accesses reach them.
    always_comb begin
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_addr = '0;
        bus.mem_wr_data = '0;
        bus.mem_rd_en   = 1'b0;
        bus.mem_rd_addr = '0;
        bus.sys_rd_data = '0;
        if (state == S_RUN) begin
            bus.mem_wr_en   = bus.sys_wr_en;
            bus.mem_wr_addr = bus.sys_wr_addr;
            bus.mem_wr_data = bus.sys_wr_data;
            bus.mem_rd_en   = bus.sys_rd_en;
            bus.mem_rd_addr = bus.sys_rd_addr;
            bus.sys_rd_data = bus.mem_rd_data;
        end else begin
            if (host_wr_ok) begin
                bus.mem_wr_en   = 1'b1;
                bus.mem_wr_addr = ptr;
                bus.mem_wr_data = bus.host_wr_data;
            end
            if (host_rd_ok) begin
                bus.mem_rd_en   = 1'b1;
                bus.mem_rd_addr = ptr;
            end
        end
    end

`ifdef SYS_WATCHDOG_EN
    logic [12:0] wd_cnt;
    logic        st_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt     <= '0;
            st_timeout <= 1'b0;
        end else begin
            if (launch) begin
                wd_cnt     <= '0;
                st_timeout <= 1'b0;
            end else if (state == S_RUN) begin
                wd_cnt <= wd_cnt + 13'd1;
            end
            if (wd_expired && !bus.sys_done)
                st_timeout <= 1'b1;
        end
    end

    assign wd_expired         = (state == S_RUN) && (wd_cnt == 13'(TIMEOUT_CYC - 1));
    assign bus.status_timeout = st_timeout;
`else
    assign wd_expired         = 1'b0;
    assign bus.status_timeout = 1'b0;
`endif

    assign bus.host_rd_data     = valid_q ? bus.mem_rd_data : '0;
    assign bus.host_rd_valid    = valid_q;
    assign bus.done_pulse       = done_q;
    assign bus.sys_start        = start_q;
    assign bus.sys_gen_left_op  = left_q;
    assign bus.sys_gen_right_op = right_q;
    assign bus.busy             = (state == S_RUN);
    assign bus.loaded           = (state == S_READY);
    assign bus.status_success   = st_success;
    assign bus.status_fail      = st_fail;
    assign bus.err_access       = err_q;
endmodule

// File: tb/tb_systemizer_seq.sv
// Randomized bench for systemizer_seq: a behavioural RAM image predicts every
// memory-port access, systemizer read return and readout word.
`timescale 1ns/1ps
module tb_systemizer_seq;
    localparam int DEPTH = 40;
    localparam int AW    = 6;
    localparam int DW    = 4;
    localparam int TMO   = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_compared   = 0;
    int   n_mismatched = 0;

    systemizer_seq_if #(.AW(AW), .DW(DW)) bus ();

    systemizer_seq #(
        .DEPTH(DEPTH), .AW(AW), .DW(DW), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Physical RAM seen by the DUT; the expected image lives separately in exp_ram.
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] ram_q = '0;
    always @(posedge clk) begin
        if (bus.mem_wr_en && bus.mem_wr_addr < AW'(DEPTH))
            ram[bus.mem_wr_addr] <= bus.mem_wr_data;
        if (bus.mem_rd_en)
            ram_q <= (bus.mem_rd_addr < AW'(DEPTH)) ? ram[bus.mem_rd_addr] : '0;
    end
    assign bus.mem_rd_data = ram_q;

    logic [DW-1:0] exp_ram [DEPTH];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic clearInputs();
        bus.host_wr_en   = 1'b0;
        bus.host_wr_data = '0;
        bus.host_rd_en   = 1'b0;
        bus.cmd_run      = 1'b0;
        bus.cmd_clear    = 1'b0;
        bus.op_left      = '0;
        bus.op_right     = '0;
        bus.sys_done     = 1'b0;
        bus.sys_success  = 1'b0;
        bus.sys_fail     = 1'b0;
        bus.sys_rd_en    = 1'b0;
        bus.sys_rd_addr  = '0;
        bus.sys_wr_en    = 1'b0;
        bus.sys_wr_addr  = '0;
        bus.sys_wr_data  = '0;
    endtask

    task automatic midCycle();
        @(negedge clk);
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
        clearInputs();
    endtask

    // A host write landing at address 0 shows the DUT is in IDLE with ptr=0; clear afterwards.
    task automatic probeIdle(input string tag);
        bus.host_wr_en   = 1'b1;
        bus.host_wr_data = 4'h9;
        midCycle();
        checkOutput({tag, "_wr_en"}, bus.mem_wr_en, 1);
        checkOutput({tag, "_wr_addr"}, bus.mem_wr_addr, 0);
        applyStimulus();
        bus.cmd_clear = 1'b1;
        applyStimulus();
    endtask

    task automatic loadMatrix(input bit patterned);
        logic [DW-1:0] d;
        for (int i = 0; i < DEPTH; i++) begin
            d = patterned ? DW'(i % 16) : DW'($urandom_range(0, 15));
            exp_ram[i]       = d;
            bus.host_wr_en   = 1'b1;
            bus.host_wr_data = d;
            midCycle();
            checkOutput("load_wr_en", bus.mem_wr_en, 1);
            checkOutput("load_wr_addr", bus.mem_wr_addr, i);
            checkOutput("load_wr_data", bus.mem_wr_data, d);
            checkOutput("load_loaded_early", bus.loaded, 0);
            applyStimulus();
        end
        midCycle();
        checkOutput("load_loaded", bus.loaded, 1);
    endtask

    task automatic launchRun(input logic [1:0] l, input logic [1:0] r);
        bus.cmd_run  = 1'b1;
        bus.op_left  = l;
        bus.op_right = r;
        midCycle();
        checkOutput("launch_start_pre", bus.sys_start, 0);
        applyStimulus();
        midCycle();
        checkOutput("launch_busy", bus.busy, 1);
        checkOutput("launch_start", bus.sys_start, 1);
        checkOutput("launch_left", bus.sys_gen_left_op, l);
        checkOutput("launch_right", bus.sys_gen_right_op, r);
        checkOutput("launch_status_clr", {bus.status_success, bus.status_fail, bus.status_timeout}, 0);
        applyStimulus();
        midCycle();
        checkOutput("launch_start_once", bus.sys_start, 0);
    endtask

    task automatic runTraffic(input int n);
        logic [DW-1:0] pend = '0;
        bit            have_pend = 1'b0;
        bit            re, we;
        int            ra, wa;
        logic [DW-1:0] wd;
        for (int i = 0; i < n; i++) begin
            re = (i < n - 1) && ($urandom_range(0, 1) == 1);
            we = ($urandom_range(0, 1) == 1);
            ra = $urandom_range(0, DEPTH - 1);
            wa = $urandom_range(0, DEPTH - 1);
            wd = DW'($urandom_range(0, 15));
            if (i == 0) begin
                re = 1'b1; ra = 17; we = 1'b1; wa = 5; wd = 4'hA;
            end
            bus.sys_rd_en    = re;
            bus.sys_rd_addr  = AW'(ra);
            bus.sys_wr_en    = we;
            bus.sys_wr_addr  = AW'(wa);
            bus.sys_wr_data  = wd;
            bus.host_wr_en   = (i == 1);
            bus.host_wr_data = 4'h3;
            bus.cmd_clear    = (i == 2);
            midCycle();
            checkOutput("run_busy", bus.busy, 1);
            checkOutput("run_wr_en", bus.mem_wr_en, we);
            checkOutput("run_rd_en", bus.mem_rd_en, re);
            if (we) begin
                checkOutput("run_wr_addr", bus.mem_wr_addr, wa);
                checkOutput("run_wr_data", bus.mem_wr_data, wd);
            end
            if (re)
                checkOutput("run_rd_addr", bus.mem_rd_addr, ra);
            if (have_pend)
                checkOutput("sys_rd_data", bus.sys_rd_data, pend);
            have_pend = re;
            if (re)
                pend = exp_ram[ra];
            if (we)
                exp_ram[wa] = wd;
            applyStimulus();
        end
        midCycle();
        checkOutput("run_host_err", bus.err_access, 1);
    endtask

    task automatic finishRun(input bit succ, input bit fl);
        bus.sys_done    = 1'b1;
        bus.sys_success = succ;
        bus.sys_fail    = fl;
        applyStimulus();
        midCycle();
        checkOutput("finish_busy", bus.busy, 0);
        checkOutput("finish_success", bus.status_success, succ && !fl);
        checkOutput("finish_fail", bus.status_fail, !(succ && !fl));
    endtask

    task automatic readoutAll();
        for (int i = 0; i < DEPTH; i++) begin
            int gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                midCycle();
                checkOutput("rdo_gap_valid", bus.host_rd_valid, 0);
                applyStimulus();
            end
            bus.host_rd_en = 1'b1;
            midCycle();
            checkOutput("rdo_rd_en", bus.mem_rd_en, 1);
            checkOutput("rdo_rd_addr", bus.mem_rd_addr, i);
            checkOutput("rdo_wr_en", bus.mem_wr_en, 0);
            applyStimulus();
            midCycle();
            checkOutput("rdo_valid", bus.host_rd_valid, 1);
            checkOutput("rdo_data", bus.host_rd_data, exp_ram[i]);
            checkOutput("rdo_done", bus.done_pulse, (i == DEPTH - 1));
            applyStimulus();
        end
        midCycle();
        checkOutput("rdo_after_valid", bus.host_rd_valid, 0);
        checkOutput("rdo_after_done", bus.done_pulse, 0);
        checkOutput("rdo_after_state", {bus.busy, bus.loaded}, 0);
        checkOutput("rdo_keep_success", bus.status_success, 1);
        applyStimulus();
        probeIdle("rdo_idle");
    endtask

    initial begin
        int cnt;
        clearInputs();
        bus.op_left  = 2'd3;
        bus.op_right = 2'd3;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        clearInputs();

        midCycle();
        checkOutput("rst_flags", {bus.busy, bus.loaded, bus.status_success, bus.status_fail,
                                  bus.status_timeout, bus.err_access, bus.done_pulse,
                                  bus.sys_start, bus.host_rd_valid}, 0);
        checkOutput("rst_ports", {bus.mem_wr_en, bus.mem_rd_en, bus.mem_wr_addr, bus.mem_rd_addr}, 0);
        checkOutput("rst_ops", {bus.sys_gen_left_op, bus.sys_gen_right_op, bus.host_rd_data}, 0);
        applyStimulus();

        bus.cmd_run = 1'b1;
        midCycle();
        checkOutput("idle_run_wr", bus.mem_wr_en, 0);
        applyStimulus();
        midCycle();
        checkOutput("idle_run_err", bus.err_access, 1);
        checkOutput("idle_run_state", {bus.busy, bus.loaded, bus.sys_start}, 0);
        applyStimulus();
        bus.cmd_clear = 1'b1;
        applyStimulus();
        midCycle();
        checkOutput("clear_err", bus.err_access, 0);
        applyStimulus();

        bus.host_wr_en = 1'b1;
        bus.host_rd_en = 1'b1;
        midCycle();
        checkOutput("both_wr_en", bus.mem_wr_en, 1);
        checkOutput("both_rd_en", bus.mem_rd_en, 0);
        applyStimulus();
        midCycle();
        checkOutput("both_err", bus.err_access, 1);
        applyStimulus();
        bus.cmd_clear = 1'b1;
        applyStimulus();

        $display("[TB] run 1: patterned load, success, readout");
        loadMatrix(1'b1);
        applyStimulus();
        bus.host_wr_en   = 1'b1;
        bus.host_wr_data = 4'hF;
        midCycle();
        checkOutput("ready_wr_dropped", bus.mem_wr_en, 0);
        applyStimulus();
        midCycle();
        checkOutput("ready_wr_err", bus.err_access, 1);
        checkOutput("ready_still", bus.loaded, 1);
        applyStimulus();
        launchRun(2'd2, 2'd1);
        applyStimulus();
        runTraffic(8);
        applyStimulus();
        finishRun(1'b1, 1'b0);
        applyStimulus();
        readoutAll();

        $display("[TB] run 2: random load, success+fail together");
        loadMatrix(1'b0);
        applyStimulus();
        launchRun(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        applyStimulus();
        runTraffic(5);
        applyStimulus();
        finishRun(1'b1, 1'b1);
        applyStimulus();
        bus.host_wr_en = 1'b1;
        midCycle();
        checkOutput("fail_wr_dropped", bus.mem_wr_en, 0);
        applyStimulus();
        bus.cmd_run = 1'b1;
        applyStimulus();
        midCycle();
        checkOutput("fail_hold", {bus.busy, bus.loaded, bus.sys_start}, 0);
        applyStimulus();
        bus.cmd_clear = 1'b1;
        applyStimulus();
        midCycle();
        checkOutput("fail_clear_err", bus.err_access, 0);
        checkOutput("fail_kept", bus.status_fail, 1);
        applyStimulus();
        probeIdle("fail_idle");

        $display("[TB] run 3: no sys_done");
        loadMatrix(1'b0);
        applyStimulus();
`ifdef SYS_WATCHDOG_EN
        bus.cmd_run = 1'b1;
        applyStimulus();
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            midCycle();
            if (!bus.busy)
                break;
            cnt++;
            applyStimulus();
        end
        checkOutput("wd_run_cycles", cnt, TMO);
        checkOutput("wd_timeout", bus.status_timeout, 1);
        checkOutput("wd_fail", bus.status_fail, 1);
        checkOutput("wd_success", bus.status_success, 0);
        applyStimulus();
`else
        launchRun(2'd1, 2'd2);
        applyStimulus();
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            midCycle();
            if (bus.busy)
                cnt++;
            applyStimulus();
        end
        checkOutput("nowd_still_busy", cnt, 100);
        midCycle();
        checkOutput("nowd_timeout", bus.status_timeout, 0);
        applyStimulus();
        finishRun(1'b0, 1'b0);
        applyStimulus();
`endif
        bus.cmd_clear = 1'b1;
        applyStimulus();
        probeIdle("run3_idle");

        $display("[TB] run 4: reset during RUN");
        loadMatrix(1'b0);
        applyStimulus();
        launchRun(2'd3, 2'd0);
        applyStimulus();
        rst = 1'b1;
        #1;
        checkOutput("rst_run_abort", {bus.busy, bus.sys_start, bus.sys_gen_left_op, bus.status_success}, 0);
        applyStimulus();
        rst = 1'b0;
        applyStimulus();
        probeIdle("rst_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
